// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and default width for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned XlenDefault = 32;

  localparam logic [3:0] OpAdd   = 4'h0;
  localparam logic [3:0] OpSub   = 4'h1;
  localparam logic [3:0] OpAnd   = 4'h2;
  localparam logic [3:0] OpOr    = 4'h3;
  localparam logic [3:0] OpXor   = 4'h4;
  localparam logic [3:0] OpSlt   = 4'h5;
  localparam logic [3:0] OpSltu  = 4'h6;
  localparam logic [3:0] OpSll   = 4'h7;
  localparam logic [3:0] OpSrl   = 4'h8;
  localparam logic [3:0] OpSra   = 4'h9;
  localparam logic [3:0] OpMul   = 4'hA;
  localparam logic [3:0] OpMulhu = 4'hB;
  localparam logic [3:0] OpDivu  = 4'hC;
  localparam logic [3:0] OpRemu  = 4'hD;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

endpackage

// File: rtl/muldiv_iter.sv
// XLEN-step unsigned shift-add multiplier / restoring divider sharing one hi/lo register pair.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  logic [CntW-1:0] r_cnt;
  logic [XLEN-1:0] r_hi, r_lo, r_b;
  logic [3:0]      r_op;

  logic [XLEN:0]   w_sum, w_rsh, w_diff;
  logic [XLEN-1:0] w_hi_next, w_lo_next;
  logic            w_is_mul;

  // Mul: hi accumulates, product shifts right into lo. Div: hi is the partial remainder,
  // lo shifts the dividend out and the quotient bits in.
  always_comb begin
    w_is_mul = (r_op == OpMul) || (r_op == OpMulhu);
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_rsh    = {r_hi, r_lo[XLEN-1]};
    w_diff   = w_rsh - {1'b0, r_b};
    if (w_is_mul) begin
      w_hi_next = w_sum[XLEN:1];
      w_lo_next = {w_sum[0], r_lo[XLEN-1:1]};
    end else begin
      w_hi_next = w_diff[XLEN] ? w_rsh[XLEN-1:0] : w_diff[XLEN-1:0];
      w_lo_next = {r_lo[XLEN-2:0], ~w_diff[XLEN]};
    end
    result = ((r_op == OpMulhu) || (r_op == OpRemu)) ? w_hi_next : w_lo_next;
    done   = (r_cnt == CntW'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
      r_op  <= OpAdd;
    end else if (start) begin
      r_cnt <= CntW'(XLEN);
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
      r_op  <= op;
    end else if (r_cnt != '0) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle ops plus iterative MUL/MULHU/DIVU/REMU behind valid/ready.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucontrol,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] aluresult,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          r_state, w_state_next;
  logic [XLEN-1:0] r_result;
  logic            r_zero;

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu, w_iter_result;
  logic            w_iter, w_start, w_iter_done;

  // Divide by zero resolves here in one cycle; only a real divisor goes iterative.
  always_comb begin
    w_shamt = srcb[SHW-1:0];
    w_alu   = '0;
    case (alucontrol)
      OpAdd:   w_alu = srca + srcb;
      OpSub:   w_alu = srca - srcb;
      OpAnd:   w_alu = srca & srcb;
      OpOr:    w_alu = srca | srcb;
      OpXor:   w_alu = srca ^ srcb;
      OpSlt:   w_alu = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      OpSltu:  w_alu = {{(XLEN-1){1'b0}}, srca < srcb};
      OpSll:   w_alu = srca << w_shamt;
      OpSrl:   w_alu = srca >> w_shamt;
      OpSra:   w_alu = $unsigned($signed(srca) >>> w_shamt);
      OpDivu:  w_alu = '1;
      OpRemu:  w_alu = srca;
      default: w_alu = '0;
    endcase
    w_iter = (alucontrol == OpMul) || (alucontrol == OpMulhu) ||
             (((alucontrol == OpDivu) || (alucontrol == OpRemu)) && (srcb != '0));
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_start      = w_iter;
          w_state_next = w_iter ? StBusy : StDone;
        end
      end
      StBusy:  if (w_iter_done) w_state_next = StDone;
      StDone:  if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_result <= '0;
      r_zero   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      if ((r_state == StIdle) && in_valid && !w_iter) begin
        r_result <= w_alu;
        r_zero   <= (w_alu == '0);
      end else if ((r_state == StBusy) && w_iter_done) begin
        r_result <= w_iter_result;
        r_zero   <= (w_iter_result == '0);
      end
    end
  end

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv_iter (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .op    (alucontrol),
    .a     (srca),
    .b     (srcb),
    .done  (w_iter_done),
    .result(w_iter_result)
  );

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign aluresult = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed literal cases plus random traffic against a latency/result model.
module tb_alu_muldiv;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alucontrol = 4'd0;
  logic [XLEN-1:0] srca = '0;
  logic [XLEN-1:0] srcb = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] aluresult;
  logic            zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(
    .XLEN(XLEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alucontrol(alucontrol),
    .srca      (srca),
    .srcb      (srcb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluresult (aluresult),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  return $unsigned($signed(a) >>> b[4:0]);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_slow(input logic [3:0] op, input logic [31:0] b);
    return (op == 4'd10) || (op == 4'd11) || (((op == 4'd12) || (op == 4'd13)) && (b != 0));
  endfunction

  // Model: 0 = can accept, 1 = computing (m_wait cycles left), 2 = result on offer.
  int          m_phase = 0;
  int          m_wait = 0;
  logic [31:0] m_res = '0;
  bit          m_clean = 1'b1;
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0;
      m_res   = '0;
      m_clean = 1'b1;
      m_live  = 1'b1;
    end else if (m_live) begin
      case (m_phase)
        0: if (in_valid) begin
          m_res   = ref_result(alucontrol, srca, srcb);
          m_clean = 1'b0;
          if (ref_slow(alucontrol, srcb)) begin
            m_phase = 1;
            m_wait  = XLEN;
          end else begin
            m_phase = 2;
          end
        end
        1: begin
          m_wait--;
          if (m_wait == 0) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", {31'd0, out_valid}, {31'd0, m_phase == 2});
      check("in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      if ((m_phase == 2) || m_clean) begin
        check("aluresult", aluresult, m_res);
        check("zero", {31'd0, zero}, {31'd0, m_res == 0});
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk); #1;
    in_valid   = 1'b1;
    alucontrol = op;
    srca       = a;
    srcb       = b;
    @(negedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check(name, aluresult, exp);
    check({name, "_zero"}, {31'd0, zero}, {31'd0, exp == 0});
    out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'($urandom_range(0, 15));
      2:       return {1'b1, 31'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    check("reset_aluresult", aluresult, 32'd0);
    check("reset_zero", {31'd0, zero}, 32'd1);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
    run_op("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 1);
    run_op("slt", 4'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'd1, 1);
    run_op("sltu", 4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0, 1);
    run_op("xor", 4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1);
    run_op("sra", 4'd9, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
    run_op("srl", 4'd8, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1);
    run_op("sll", 4'd7, 32'h0000_0001, 32'd31, 32'h8000_0000, 1);
    run_op("mul", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op("mulhu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_by0", 4'd10, 32'h1234_5678, 32'd0, 32'd0, 33);
    run_op("divu", 4'd12, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 4'd13, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0", 4'd12, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 4'd13, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("unused_e", 4'd14, 32'h1234, 32'h5678, 32'd0, 1);

    // Backpressure: result held while out_ready is low; new requests ignored.
    @(negedge clk); #1;
    in_valid = 1'b1; alucontrol = 4'd1; srca = 32'd9; srcb = 32'd4;
    @(negedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2); alucontrol = 4'd0; srca = 32'(i); srcb = 32'd0;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_result", aluresult, 32'd5);
      check("bp_zero", {31'd0, zero}, 32'd0);
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of a multiply discards it.
    @(negedge clk); #1;
    in_valid = 1'b1; alucontrol = 4'd10; srca = 32'd3; srcb = 32'd5;
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_aluresult", aluresult, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (out_valid) check("rst_no_output", {31'd0, out_valid}, 32'd0);
    end

    // Random traffic, including occasional resets; checked every cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #1;
      in_valid   = 1'($urandom_range(0, 1));
      alucontrol = 4'($urandom_range(0, 15));
      srca       = pick();
      srcb       = pick();
      out_ready  = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk); #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised-width successor to the core's single-cycle ALU.
- Adds XOR, signed and unsigned compare, and the three shifts.
- Adds iterative unsigned multiply and divide (MUL, MULHU, DIVU, REMU).
- Sits in the execute stage behind a valid/ready handshake. The control unit stalls the pipeline while a multi-cycle op is in flight.

Parameters:
- XLEN, 32: datapath width. Must be a power of two, >= 8.
- SHW, $clog2(XLEN): shift-amount width. Derived localparam, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and alucontrol are valid.
- in_ready  out  1  unit can accept an op this cycle.
- alucontrol  in  4  operation select (encodings below).
- srca  in  XLEN  operand A.
- srcb  in  XLEN  operand B.
- out_valid  out  1  aluresult and zero are valid.
- out_ready  in  1  consumer takes the result this cycle.
- aluresult  out  XLEN  registered result.
- zero  out  1  registered (aluresult == 0).

Behaviour:
- Encodings, 3-bit legacy values zero-extended:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110
  - SLL 0111, SRL 1000, SRA 1001
  - MUL 1010, MULHU 1011, DIVU 1100, REMU 1101
  - 1110 and 1111 are unused: result 0, single-cycle.
- Arithmetic and width rules:
  - SLT is signed; SLTU is unsigned. Both return a 0/1 value zero-extended to XLEN.
  - Shift amount is srcb[SHW-1:0]; upper srcb bits are ignored. SRA sign-fills.
  - ADD/SUB wrap modulo 2^XLEN.
  - MUL returns the low XLEN bits of the 2*XLEN product; MULHU returns the high XLEN bits. Both unsigned.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready=1, out_valid=0. A transfer occurs when in_valid=1; operands and op are latched.
  - Single-cycle op, or DIVU/REMU with srcb==0: go to DONE with the result registered.
  - MUL/MULHU/DIVU/REMU with srcb!=0: go to BUSY, load the iteration counter with XLEN.
  - BUSY: in_ready=0, out_valid=0. One shift-add (mul) or restoring-subtract (div) step per cycle; counter decrements. When the counter reaches 1, the final step is taken, the result is registered and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0. aluresult and zero are held stable. When out_ready=1, go to IDLE.
  - No accept is possible in DONE. Throughput is one op per two cycles minimum.
- Latency, accept on edge N:
  - Single-cycle ops: out_valid visible after edge N+1.
  - Iterative ops: exactly XLEN BUSY cycles; out_valid visible after edge N+1+XLEN.
- Divide by zero (RISC-V semantics): DIVU -> all ones, REMU -> srca, single-cycle latency.
- MUL/MULHU with srcb==0 still iterate for the full XLEN cycles, giving deterministic latency.
- in_valid and operand changes during BUSY/DONE are ignored.
- Reset, highest priority, including mid-BUSY or in DONE:
  - State IDLE, in_ready=1, out_valid=0, aluresult=0, zero=1, counter=0.
  - An in-flight op is discarded; no output is produced.
- out_ready asserted while not in DONE has no effect.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit op-code localparams (ADD..REMU);
  - the FSM state encoding (IDLE, BUSY, DONE);
  - default XLEN.
- One sub-module, muldiv_iter:
  - holds the XLEN-step shift-add multiplier / restoring divider datapath and the iteration counter;
  - interface: start, op, a, b, done, result.
- Top level holds the combinational single-cycle ops, the FSM, and the output registers.

Test Plan (XLEN=32):
1. ADD 0x7FFFFFFF + 0x00000001 -> aluresult 0x80000000, zero=0. out_valid one cycle after accept. SUB 5-5 -> 0, zero=1.
2. SLT 0xFFFFFFFF vs 0x00000001 -> 1. SLTU same operands -> 0. XOR 0xF0F0F0F0 ^ 0xFFFF0000 -> 0x0F0FF0F0.
3. SRA 0x80000000 by srcb=0x00000024 (masked to 4) -> 0xF8000000. SRL same -> 0x08000000. SLL 1 by 31 -> 0x80000000.
4. MUL 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000001; MULHU same -> 0xFFFFFFFE. out_valid exactly 33 cycles after accept; in_ready=0 throughout.
5. DIVU 100/7 -> 14; REMU -> 2 (33-cycle latency). DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234 (1-cycle latency).
6. Backpressure and reset:
   - Hold out_ready=0 for 5 cycles in DONE -> aluresult/zero stable, in_valid pulses ignored.
   - Assert reset at BUSY cycle 10 -> next cycle out_valid=0, in_ready=1, aluresult=0, zero=1; no result emitted.
